// File: rtl/bnn_accum_thresh.sv
// bnn_accum_thresh: accumulates one neuron's signed products with saturation,
// then holds a thresholded binary activation until the consumer takes it.
module bnn_accum_thresh #(
    parameter int IN_WIDTH  = 14,
    parameter int ACC_WIDTH = 18,
    parameter int MAX_TERMS = 64,
    localparam int CW = $clog2(MAX_TERMS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    input  logic                        in_last,
    input  logic signed [ACC_WIDTH-1:0] thr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        out_bit,
    output logic                        out_sat,
    output logic [CW-1:0]               out_count,
    output logic                        out_forced
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_WIDTH-1:0] MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t state, next_state;
    logic signed [ACC_WIDTH-1:0] acc, thr_q, base, thr_eff, clamped;
    logic signed [ACC_WIDTH:0] wide;
    logic [CW-1:0] count, count_nx;
    logic sat, sat_nx, clip, first, take, close, done;

    always_comb begin
        first    = count == '0;
        take     = in_valid && state == ACCUM;
        done     = out_ready && state == HOLD;
        base     = first ? '0 : acc;
        // One guard bit is enough: a single add can overflow by at most one bit.
        wide     = {base[ACC_WIDTH-1], base}
                 + {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        clip     = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
        clamped  = clip ? (wide[ACC_WIDTH] ? MIN_V : MAX_V) : wide[ACC_WIDTH-1:0];
        sat_nx   = sat | clip;
        thr_eff  = first ? thr : thr_q;
        count_nx = count + 1'b1;
        close    = take && (in_last || count_nx == CW'(MAX_TERMS));
        next_state = state == ACCUM ? (close ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
        in_ready   = state == ACCUM;
        out_valid  = state == HOLD;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= ACCUM;
        else state <= next_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            thr_q      <= '0;
            count      <= '0;
            sat        <= 1'b0;
            out_sum    <= '0;
            out_bit    <= 1'b0;
            out_sat    <= 1'b0;
            out_count  <= '0;
            out_forced <= 1'b0;
        end else begin
            if (take) begin
                acc   <= clamped;
                count <= count_nx;
                sat   <= sat_nx;
                if (first) thr_q <= thr;
            end
            if (close) begin
                out_sum    <= clamped;
                out_bit    <= clamped >= thr_eff;
                out_sat    <= sat_nx;
                out_count  <= count_nx;
                out_forced <= !in_last;
            end
            if (done) begin
                count <= '0;
                sat   <= 1'b0;
            end
        end
    end
endmodule
